// File: rtl/if_stage_pkg.sv
// Shared constants for the fetch stage and the decoder.
//  RESET_PC_DEF  : default PC loaded by reset
//  NOP_INSTR_DEF : bubble word (sll $0,$0,0)
//  OP_*          : primary opcode field values (instr[31:26])
//  if_id_t       : IF/ID pipeline register contents
//  br_offset()   : word-scaled, sign-extended branch displacement
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc4;
    logic [31:0] instr;
  } if_id_t;

  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/if_npc.sv
// Next-PC select for the fetch stage (purely combinational).
//  pc, if_id_pc4, if_id_instr : current PC and IF/ID contents
//  taken, id_jump             : redirect request and its kind
//  pc4                        : pc + 4 (also captured into IF/ID)
//  npc                        : next PC (pc4, branch target or jump target)
module if_npc
  import if_stage_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] if_id_pc4,
  input  logic [31:0] if_id_instr,
  input  logic        taken,
  input  logic        id_jump,
  output logic [31:0] pc4,
  output logic [31:0] npc
);

  logic [31:0] br_tgt;
  logic [31:0] j_tgt;

  // All adds wrap modulo 2^32; carry out is intentionally dropped.
  assign pc4    = pc + 32'd4;
  assign br_tgt = if_id_pc4 + br_offset(if_id_instr[15:0]);
  assign j_tgt  = {if_id_pc4[31:28], if_id_instr[25:0], 2'b00};

  // Jump wins if both are flagged.
  always_comb begin
    npc = pc4;
    if (taken) npc = id_jump ? j_tgt : br_tgt;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, imem address, IF/ID register.
//  clk, rst          : clock, synchronous active-high reset
//  stall             : hold PC and IF/ID
//  id_branch, id_eq  : beq in IF/ID and its operand compare
//  id_jump           : j in IF/ID
//  imem_addr/rdata   : instruction memory (combinational read)
//  pc                : current fetch PC
//  if_id_pc4/instr   : IF/ID contents, if_id_valid = 0 marks a bubble
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        id_branch,
  input  logic        id_eq,
  input  logic        id_jump,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
);

  logic [31:0] pc_q;
  if_id_t      if_id_q;
  logic        taken;
  logic [31:0] pc4;
  logic [31:0] npc;

  // A bubble never redirects, and a stalled redirect waits for operands.
  assign taken = if_id_q.valid & ~stall & ((id_branch & id_eq) | id_jump);

  if_npc u_npc (
    .pc          (pc_q),
    .if_id_pc4   (if_id_q.pc4),
    .if_id_instr (if_id_q.instr),
    .taken       (taken),
    .id_jump     (id_jump),
    .pc4         (pc4),
    .npc         (npc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      if_id_q.valid <= 1'b0;
      if_id_q.pc4   <= 32'd0;
      if_id_q.instr <= NOP_INSTR;
    end else if (!stall) begin
      pc_q <= npc;
      if (taken) begin
        // Squash the wrong-path fetch; pc4 left as is.
        if_id_q.valid <= 1'b0;
        if_id_q.instr <= NOP_INSTR;
      end else begin
        if_id_q.valid <= 1'b1;
        if_id_q.pc4   <= pc4;
        if_id_q.instr <= imem_rdata;
      end
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign if_id_pc4   = if_id_q.pc4;
  assign if_id_instr = if_id_q.instr;
  assign if_id_valid = if_id_q.valid;

endmodule
